// File: rtl/cpa_seq_ctrl.sv
// Byte-serial multi-precision add/sub over one shared 8-bit carry-propagate adder.
// start->done takes NBYTES+1 edges; start is accepted only in IDLE and never queued.

module cpa (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_s,
  output logic       o_c2,
  output logic       o_c3
);
  logic [7:0] w_low;
  logic [1:0] w_high;

  // Split at bit 7 so the carry into the MSB is visible for overflow detection.
  assign w_low  = {1'b0, i_a[6:0]} + {1'b0, i_b[6:0]} + {7'b0, i_ci};
  assign w_high = {1'b0, i_a[7]} + {1'b0, i_b[7]} + {1'b0, w_low[7]};
  assign o_s    = {w_high[0], w_low[6:0]};
  assign o_c2   = w_low[7];
  assign o_c3   = w_high[1];
endmodule

module cpa_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                zero
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  logic [KW-1:0] r_k;
  logic          r_carry;
  logic          r_busy;
  logic          r_done;
  logic          r_cout;
  logic          r_ovf;
  logic          r_zero;

  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_s;
  logic          w_c2;
  logic          w_c3;
  logic [W-1:0]  w_res_next;

  assign w_a_byte = 8'(r_a >> {r_k, 3'b000});
  assign w_b_byte = 8'(r_b >> {r_k, 3'b000});

  cpa u_cpa (
    .i_a  (w_a_byte),
    .i_b  (w_b_byte),
    .i_ci (r_carry),
    .o_s  (w_s),
    .o_c2 (w_c2),
    .o_c3 (w_c3)
  );

  // The slot for byte k is still zero from the accept-time clear, so OR merges it in.
  assign w_res_next = r_result | (W'(w_s) << {r_k, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_k      <= '0;
      r_carry  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= sub ? ~b : b;
            r_carry  <= sub;
            r_k      <= '0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_res_next;
          r_carry  <= w_c3;
          if (r_k == K_LAST) begin
            r_cout  <= w_c3;
            r_ovf   <= w_c2 ^ w_c3;
            r_zero  <= (w_res_next == '0);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;
endmodule

// File: tb/tb_cpa_seq_ctrl.sv
// Randomised and directed bench for cpa_seq_ctrl against a whole-word arithmetic model.
module tb_cpa_seq_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] result;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cpa_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  // Reference: full-width arithmetic with sign-based overflow rule.
  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         o;
    if (s) full = {1'b0, x} - {1'b0, y} + {1'b1, {W{1'b0}}};
    else   full = {1'b0, x} + {1'b0, y};
    r = full[W-1:0];
    if (s) o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {full[W], o, (r == '0), r};
  endfunction

  // Runs one op from IDLE; lat counts edges after the accept edge until done is seen.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output int lat);
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; sub = $urandom_range(0, 1);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s);
    logic [W+2:0] exp;
    int lat;
    exp = model(x, y, s);
    do_op(x, y, s, lat);
    n_total++; if (lat !== NB) $display("FAIL %s latency got %0d want %0d", name, lat, NB); else n_pass++;
    n_total++; if (result !== exp[W-1:0]) $display("FAIL %s result got %h want %h", name, result, exp[W-1:0]); else n_pass++;
    n_total++; if (cout !== exp[W+2]) $display("FAIL %s cout got %b want %b", name, cout, exp[W+2]); else n_pass++;
    n_total++; if (ovf !== exp[W+1]) $display("FAIL %s ovf got %b want %b", name, ovf, exp[W+1]); else n_pass++;
    n_total++; if (zero !== exp[W]) $display("FAIL %s zero got %b want %b", name, zero, exp[W]); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL %s idle busy=%b done=%b want 0 0", name, busy, done); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, result, cout, ovf, zero} !== '0)
      $display("FAIL reset outputs got busy=%b done=%b result=%h flags=%b%b%b want all 0",
               busy, done, result, cout, ovf, zero);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op("add_carry", 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0);
    check_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1);
    check_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b1);
    check_op("sub_equal", 32'h12345678, 32'h12345678, 1'b1);
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = $urandom; y = $urandom;
      if (i % 6 == 0) y = ~x + ((i % 12 == 0) ? 32'd1 : 32'd0);
      check_op("random", x, y, 1'(($urandom_range(0, 1))));
    end
  endtask

  task automatic test_busy_ignore();
    int lat, n_done;
    start = 1'b1; sub = 1'b0; a = 32'h10; b = 32'h20;
    @(posedge clk); #1;
    start = 1'b0;
    n_total++; if (busy !== 1'b1 || result !== '0) $display("FAIL accept busy=%b result=%h want 1 0", busy, result); else n_pass++;
    n_done = 0;
    for (lat = 1; lat <= 10; lat++) begin
      start = (lat == 2 || lat == 5); a = 32'h11111111; b = 32'h11111111;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        n_total++; if (result !== 32'h30) $display("FAIL busy_ignore result got %h want 00000030", result); else n_pass++;
      end
    end
    start = 1'b0;
    n_total++; if (n_done !== 1) $display("FAIL busy_ignore done count got %0d want 1", n_done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL busy_ignore trailing busy got %b want 0", busy); else n_pass++;
    check_op("after_ignore", 32'hA5A5A5A5, 32'h01020304, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] e1;
    int lat;
    e1 = model(32'h80000000, 32'h80000000, 1'b0);
    do_op(32'h80000000, 32'h80000000, 1'b0, lat);
    @(posedge clk); #1;
    start = 1'b1; sub = 1'b0; a = 32'h1; b = 32'h2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({cout, ovf, zero} !== {e1[W+2], e1[W+1], e1[W]})
      $display("FAIL flag_hold got %b%b%b want %b%b%b", cout, ovf, zero, e1[W+2], e1[W+1], e1[W]);
    else n_pass++;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_total++; if (result !== 32'h3 || {cout, ovf, zero} !== 3'b000) $display("FAIL b2b second result=%h flags=%b%b%b want 00000003 000", result, cout, ovf, zero); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int n_done;
    start = 1'b1; sub = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if ({busy, done, result, cout, ovf, zero} !== '0)
      $display("FAIL reset_mid outputs busy=%b done=%b result=%h flags=%b%b%b want all 0",
               busy, done, result, cout, ovf, zero);
    else n_pass++;
    n_done = 0;
    repeat (8) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) n_done++; end
    n_total++; if (n_done !== 0) $display("FAIL reset_mid stray activity got %0d cycles want 0", n_done); else n_pass++;
    check_op("after_reset", 32'h000000FF, 32'h00000001, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
